// File: rtl/dualmem_param_pkg.sv
// rtl/dualmem_param_pkg.sv - shared types and helpers for the parametrised dual-port RAM
package dualmem_param_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int calc_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dualmem_param_if.sv
// rtl/dualmem_param_if.sv - two-port RAM access bundle with user/RAM modports
interface dualmem_param_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 13
) ();
    import dualmem_param_pkg::*;

    localparam int BYTES = calc_bytes(DATA_WIDTH);

    logic                  init_done;
    logic                  ena;
    logic [BYTES-1:0]      wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] douta;
    logic                  douta_valid;
    logic                  enb;
    logic [BYTES-1:0]      web;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dinb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  doutb_valid;

    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb,
        input  init_done, douta, douta_valid, doutb, doutb_valid
    );

    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb,
        output init_done, douta, douta_valid, doutb, doutb_valid
    );

endinterface

// File: rtl/dualmem_param_core.sv
// rtl/dualmem_param_core.sv - raw byte-write true dual-port array, read-first, port A wins collisions
module dualmem_param_core
    import dualmem_param_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 13,
    localparam int BYTES      = calc_bytes(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  en_a_i,
    input  logic [BYTES-1:0]      we_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [DATA_WIDTH-1:0] din_a_i,
    output logic [DATA_WIDTH-1:0] dout_a_o,
    input  logic                  en_b_i,
    input  logic [BYTES-1:0]      we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] din_b_i,
    output logic [DATA_WIDTH-1:0] dout_b_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout_a_q;
    logic [DATA_WIDTH-1:0] dout_b_q;

    // Port A byte writes are scheduled after port B so A's data lands on shared bytes.
    always_ff @(posedge clk_i) begin
        if (en_a_i) dout_a_q <= mem_q[addr_a_i];
        if (en_b_i) dout_b_q <= mem_q[addr_b_i];
        for (int i = 0; i < BYTES; i++) begin
            if (en_b_i && we_b_i[i]) mem_q[addr_b_i][i*8 +: 8] <= din_b_i[i*8 +: 8];
            if (en_a_i && we_a_i[i]) mem_q[addr_a_i][i*8 +: 8] <= din_a_i[i*8 +: 8];
        end
    end

    assign dout_a_o = dout_a_q;
    assign dout_b_o = dout_b_q;

endmodule

// File: rtl/dualmem_param.sv
// rtl/dualmem_param.sv - dual-port RAM with post-reset clear sequencer and per-port read valids
module dualmem_param
    import dualmem_param_pkg::*;
#(
    parameter  int DATA_WIDTH     = 64,
    parameter  int ADDR_WIDTH     = 13,
    parameter  int OUT_REG        = 0,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int BYTES          = calc_bytes(DATA_WIDTH)
) (
    input  logic           clk,
    input  logic           rstn,
    dualmem_param_if.slave bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  init_done_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= (state_d == ST_READY);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    logic clearing;
    logic acc_a, acc_b;
    logic rd_a, rd_b;

    assign clearing = (state_q == ST_CLEAR);
    assign acc_a    = bus.ena & init_done_q;
    assign acc_b    = bus.enb & init_done_q;
    assign rd_a     = acc_a & ~(|bus.wea);
    assign rd_b     = acc_b & ~(|bus.web);

    logic [1:0][DATA_WIDTH-1:0] core_dout;

    // The clear sequencer owns core port A until the sweep finishes.
    dualmem_param_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .clk_i   (clk),
        .en_a_i  (clearing | acc_a),
        .we_a_i  (clearing ? {BYTES{1'b1}} : bus.wea),
        .addr_a_i(clearing ? clr_cnt_q : bus.addra),
        .din_a_i (clearing ? {DATA_WIDTH{1'b0}} : bus.dina),
        .dout_a_o(core_dout[0]),
        .en_b_i  (acc_b),
        .we_b_i  (bus.web),
        .addr_b_i(bus.addrb),
        .din_b_i (bus.dinb),
        .dout_b_o(core_dout[1])
    );

    logic [1:0]                 rd1_q;
    logic [1:0]                 vld_w;
    logic [1:0][DATA_WIDTH-1:0] dout_w;

    always_ff @(posedge clk) begin
        if (!rstn) rd1_q <= '0;
        else       rd1_q <= {rd_b, rd_a};
    end

    if (OUT_REG != 0) begin : g_outreg
        logic [1:0]                 rd2_q;
        logic [1:0][DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                rd2_q  <= '0;
                dout_q <= '0;
            end else begin
                rd2_q <= rd1_q;
                for (int p = 0; p < 2; p++) begin
                    if (rd1_q[p]) dout_q[p] <= core_dout[p];
                end
            end
        end

        assign vld_w  = rd2_q;
        assign dout_w = dout_q;
    end else begin : g_noreg
        // Core output is live only on the valid cycle; otherwise replay the last read.
        logic [1:0][DATA_WIDTH-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (!rstn) hold_q <= '0;
            else       hold_q <= dout_w;
        end

        always_comb begin
            dout_w = hold_q;
            for (int p = 0; p < 2; p++) begin
                if (rd1_q[p]) dout_w[p] = core_dout[p];
            end
        end

        assign vld_w = rd1_q;
    end

    assign bus.init_done   = init_done_q;
    assign bus.douta       = dout_w[0];
    assign bus.doutb       = dout_w[1];
    assign bus.douta_valid = vld_w[0];
    assign bus.doutb_valid = vld_w[1];

endmodule
